// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter sharing one single-ported data memory
// between port 0 (CPU) and port 1 (DMA), with burst lock and lock watchdog.
//
// Ports:
//   clk, reset (async, active-low)
//   reqN/weN/addrN/wdataN/lockN : requester N inputs
//   gntN    : port N owns the memory this cycle
//   rvalidN : one-cycle read-complete pulse, rdataN registered read data
//   errN    : one-cycle out-of-range pulse
//   mem_addr/mem_wdata/mem_read/mem_write : memory strobes (combinational)
//   mem_rdata : memory read data (combinational from mem_addr)
module data_mem_arbiter #(
    parameter int RAM_SIZE = 256,
    parameter int MAX_LOCK = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam int LCW = $clog2(MAX_LOCK + 1);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);
    localparam logic [31:0] ADDR_LIM = 32'(RAM_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
    logic            rvalid0_q, rvalid0_d;
    logic            rvalid1_q, rvalid1_d;
    logic            err0_q, err0_d;
    logic            err1_q, err1_d;
    logic [31:0]     rdata0_q, rdata0_d;
    logic [31:0]     rdata1_q, rdata1_d;

    logic acc0, acc1;
    logic inr0, inr1;
    logic lock_ok;

    assign gnt0 = (state_q == OWN0);
    assign gnt1 = (state_q == OWN1);
    assign acc0 = gnt0 & req0;
    assign acc1 = gnt1 & req1;
    assign inr0 = (addr0 < ADDR_LIM);
    assign inr1 = (addr1 < ADDR_LIM);
    assign lock_ok = (lock_cnt_q < LOCK_MAX);

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

    // Strobes are suppressed for out-of-range accesses so memory is untouched.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (acc0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_read  = inr0 & ~we0;
            mem_write = inr0 & we0;
        end else if (acc1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_read  = inr1 & ~we1;
            mem_write = inr1 & we1;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        last_d     = last_q;
        unique case (state_q)
            IDLE: begin
                lock_cnt_d = '0;
                if (req0 && req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                // Lock extends ownership until the watchdog count is reached.
                if (req0 && lock0 && lock_ok) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end else begin
                    lock_cnt_d = '0;
                    if (req1) begin
                        state_d = OWN1;
                    end else if (!req0) begin
                        state_d = IDLE;
                    end
                end
            end
            OWN1: begin
                if (req1 && lock1 && lock_ok) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end else begin
                    lock_cnt_d = '0;
                    if (req0) begin
                        state_d = OWN0;
                    end else if (!req1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
        if (acc0) begin
            last_d = 1'b0;
        end else if (acc1) begin
            last_d = 1'b1;
        end
    end

    // Out-of-range reads still complete (rvalid) but return zero data.
    always_comb begin
        rvalid0_d = acc0 & ~we0;
        rvalid1_d = acc1 & ~we1;
        err0_d    = acc0 & ~inr0;
        err1_d    = acc1 & ~inr1;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (rvalid0_d) begin
            rdata0_d = inr0 ? mem_rdata : '0;
        end
        if (rvalid1_d) begin
            rdata1_d = inr1 ? mem_rdata : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and random checks of data_mem_arbiter
// against a cycle-level behavioural model with its own memory image.
module tb_data_mem_arbiter;

    localparam int MAXL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  req, we, lk;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    data_mem_arbiter #(.RAM_SIZE(256), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .reset(reset),
        .req0(req[0]), .req1(req[1]),
        .we0(we[0]), .we1(we[1]),
        .addr0(addr[0]), .addr1(addr[1]),
        .wdata0(wdata[0]), .wdata1(wdata[1]),
        .lock0(lk[0]), .lock1(lk[1]),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_val(int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'h1000_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // memory attached to the arbiter
    logic [31:0] ram [64];
    logic        ram_ok = 1'b0;
    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clk) begin
        if (!ram_ok) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
            ram_ok <= 1'b1;
        end else if (mem_write) begin
            ram[mem_addr[7:2]] <= mem_wdata;
        end
    end

    // reference model state
    logic [31:0] ref_mem [64];
    int          m_own;
    int          m_last;
    int          m_cnt;
    logic [1:0]  m_rv, m_er;
    logic [31:0] m_rd [2];

    int   nchk = 0;
    int   nerr = 0;
    logic [1:0] done;
    logic g0_s, g1_s, mr_s;
    int   mw_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_last = 1;
        m_cnt  = 0;
        m_rv   = 2'b00;
        m_er   = 2'b00;
        m_rd[0] = '0;
        m_rd[1] = '0;
    endtask

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic l);
        req[p]   = r;
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
        lk[p]    = l;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req = '0; we = '0; lk = '0;
        @(posedge clk);
        #1;
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_rv", 32'({rvalid1, rvalid0}), 0);
        chk("rst_err", 32'({err1, err0}), 0);
        chk("rst_rd0", rdata0, 0);
        chk("rst_rd1", rdata1, 0);
        chk("rst_strb", 32'({mem_read, mem_write}), 0);
        chk("rst_maddr", mem_addr, 0);
        model_reset();
        reset = 1'b1;
    endtask

    // one clock cycle: check at negedge, advance model, return at posedge+1
    task automatic step();
        logic [1:0] acc, inr;
        logic exp_rd, exp_wr;
        int ap, own_n, cnt_n, o;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            acc[p] = (m_own == p) && req[p];
            inr[p] = addr[p] < 32'd256;
        end
        g0_s = gnt0;
        g1_s = gnt1;
        mr_s = mem_read;
        if (mem_write) mw_cnt++;
        exp_rd = (acc[0] && inr[0] && !we[0]) || (acc[1] && inr[1] && !we[1]);
        exp_wr = (acc[0] && inr[0] && we[0]) || (acc[1] && inr[1] && we[1]);
        chk("gnt0", 32'(gnt0), 32'(m_own == 0));
        chk("gnt1", 32'(gnt1), 32'(m_own == 1));
        chk("mem_read", 32'(mem_read), 32'(exp_rd));
        chk("mem_write", 32'(mem_write), 32'(exp_wr));
        if (acc != 2'b00) begin
            ap = acc[0] ? 0 : 1;
            if (inr[ap]) chk("mem_addr", mem_addr, addr[ap]);
            if (inr[ap] && we[ap]) chk("mem_wdata", mem_wdata, wdata[ap]);
        end else begin
            chk("mem_addr_idle", mem_addr, 0);
            chk("mem_wdata_idle", mem_wdata, 0);
        end
        chk("rvalid0", 32'(rvalid0), 32'(m_rv[0]));
        chk("rvalid1", 32'(rvalid1), 32'(m_rv[1]));
        chk("err0", 32'(err0), 32'(m_er[0]));
        chk("err1", 32'(err1), 32'(m_er[1]));
        chk("rdata0", rdata0, m_rd[0]);
        chk("rdata1", rdata1, m_rd[1]);
        done = acc;

        own_n = -1;
        cnt_n = 0;
        if (m_own < 0) begin
            if (req[0] && req[1]) own_n = 1 - m_last;
            else if (req[0]) own_n = 0;
            else if (req[1]) own_n = 1;
        end else begin
            o = 1 - m_own;
            if (req[m_own] && lk[m_own] && m_cnt < MAXL) begin
                own_n = m_own;
                cnt_n = m_cnt + 1;
            end else if (req[o]) begin
                own_n = o;
            end else if (req[m_own]) begin
                own_n = m_own;
            end
        end
        for (int p = 0; p < 2; p++) begin
            m_rv[p] = acc[p] && !we[p];
            m_er[p] = acc[p] && !inr[p];
            if (m_rv[p]) m_rd[p] = inr[p] ? ref_mem[addr[p][7:2]] : 32'h0;
        end
        for (int p = 0; p < 2; p++)
            if (acc[p] && we[p] && inr[p]) ref_mem[addr[p][7:2]] = wdata[p];
        if (acc[0]) m_last = 0;
        else if (acc[1]) m_last = 1;
        m_own = own_n;
        m_cnt = cnt_n;
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int p);
        logic [5:0]  w6;
        logic [31:0] a;
        w6 = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 9) == 0)
            a = 32'h100 + ($urandom & 32'h0000_FFFC);
        else
            a = {24'h0, w6, 2'b00};
        set_port(p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom,
                 $urandom_range(0, 3) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        logic gs [12];
        int run, alt_bad, wc0, bad;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        done = '0;
        model_reset();
        apply_reset();

        // single read on port 0
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        step();
        step();
        chk("rd_gnt0", 32'(g0_s), 1);
        chk("rd_mread", 32'(mr_s), 1);
        req[0] = 1'b0;
        chk("rd_rvalid0", 32'(rvalid0), 1);
        chk("rd_dbeef", rdata0, 32'hDEAD_BEEF);
        chk("rd_quiet1", 32'({gnt1, rvalid1, err1}), 0);
        step();

        // port 1 write then port 0 read back
        wc0 = mw_cnt;
        set_port(1, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            if (done[1]) break;
        end
        chk("wr_done", 32'(done[1]), 1);
        req[1] = 1'b0;
        set_port(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            if (done[0]) break;
        end
        chk("rb_done", 32'(done[0]), 1);
        req[0] = 1'b0;
        chk("rb_data", rdata0, 32'h1234_5678);
        step();
        chk("wr_once", 32'(mw_cnt - wc0), 1);

        // continuous requests without lock alternate
        apply_reset();
        set_port(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        set_port(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        alt_bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            gs[c] = g0_s;
            if (c >= 1 && !(g0_s ^ g1_s)) alt_bad++;
            if (c >= 2 && gs[c] == gs[c-1]) alt_bad++;
        end
        chk("alt_first0", 32'(gs[1]), 1);
        chk("alt_bad", 32'(alt_bad), 0);

        // lock on port 0 with watchdog handover
        apply_reset();
        set_port(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1);
        set_port(1, 1'b1, 1'b0, 32'hC, 32'h0, 1'b0);
        run = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            gs[c] = g1_s;
            if (c >= 1 && c <= 7 && g0_s && run == c - 1) run++;
        end
        chk("lock_run", 32'(run), 5);
        chk("lock_hand1", 32'(gs[6]), 1);
        chk("lock_back0", 32'(gs[7]), 0);
        req = '0;
        lk = '0;
        step();

        // out-of-range read and write
        set_port(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            if (done[0]) break;
        end
        req[0] = 1'b0;
        chk("oor_rd_err", 32'({err0, rvalid0}), 32'h3);
        chk("oor_rd_data", rdata0, 0);
        set_port(1, 1'b1, 1'b1, 32'h104, 32'hBAD0_BAD0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            if (done[1]) break;
        end
        req[1] = 1'b0;
        chk("oor_wr_err", 32'({err1, rvalid1}), 32'h2);
        step();

        // reset in the middle of a port 1 write access
        set_port(1, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 1'b0);
        step();
        chk("rw_pre_gnt1", 32'({gnt1, mem_write}), 32'h3);
        #2;
        reset = 1'b0;
        #1;
        chk("rw_gnt1", 32'(gnt1), 0);
        chk("rw_mwrite", 32'(mem_write), 0);
        chk("rw_maddr", mem_addr, 0);
        chk("rw_outs", 32'({rvalid0, rvalid1, err0, err1}), 0);
        chk("rw_rdata", rdata0 | rdata1, 0);
        req = '0;
        @(posedge clk);
        #1;
        chk("rw_ram", ram[12], ref_mem[12]);
        model_reset();
        reset = 1'b1;

        // randomized traffic
        req = '0;
        done = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (done[p] || !req[p]) begin
                    if ($urandom_range(0, 99) < (done[p] ? 60 : 40))
                        new_req(p);
                    else
                        req[p] = 1'b0;
                end
            end
            step();
        end
        req = '0;
        step();
        step();

        bad = 0;
        for (int i = 0; i < 64; i++)
            if (ram[i] !== ref_mem[i]) bad++;
        chk("ram_final", 32'(bad), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
